// File: rtl/quad_encoder_emulator_pkg.sv
// Shared types and phase helpers for the quadrature encoder emulator.
// The forward {A,B} sequence lives here so generator and decoder agree on it.
package quad_encoder_emulator_pkg;

  localparam int COUNT_W_DEF  = 32;
  localparam int PERIOD_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Forward order, slot 0 in the top bits: 00 -> 10 -> 11 -> 01
  localparam logic [7:0] FWD_SEQ = {2'b00, 2'b10, 2'b11, 2'b01};

  function automatic logic [1:0] phase_next(
    input logic [1:0] ph,
    input logic       fwd
  );
    logic [1:0] idx;
    logic [1:0] nidx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (FWD_SEQ[7-2*i -: 2] == ph) idx = 2'(i);
    end
    nidx = fwd ? idx + 2'd1 : idx - 2'd1;
    return FWD_SEQ[7-2*nidx -: 2];
  endfunction

endpackage

// File: rtl/quad_encoder_emulator_phase_gen.sv
// Phase register and signed position counter.
// Moves one quadrature step per strobe in the latched direction.
module quad_phase_gen
  import quad_encoder_emulator_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_step,
  input  logic                      i_fwd,
  output logic                      o_ch_a,
  output logic                      o_ch_b,
  output logic signed [COUNT_W-1:0] o_position
);

  logic [1:0]         r_phase;
  logic [COUNT_W-1:0] r_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 2'b00;
      r_pos   <= '0;
    end else if (i_step) begin
      r_phase <= phase_next(r_phase, i_fwd);
      r_pos   <= i_fwd ? r_pos + COUNT_W'(1) : r_pos - COUNT_W'(1);
    end
  end

  assign o_ch_a     = r_phase[1];
  assign o_ch_b     = r_phase[0];
  assign o_position = r_pos;

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns signed step commands into
// evenly spaced A/B edges and tracks the emitted position.
module quad_encoder_emulator
  import quad_encoder_emulator_pkg::*;
#(
  parameter int COUNT_W  = COUNT_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [COUNT_W-1:0] cmd_steps,
  input  logic [PERIOD_W-1:0]       edge_period,
  input  logic                      abort,
  output logic                      ch_A,
  output logic                      ch_B,
  output logic                      busy,
  output logic signed [COUNT_W-1:0] position,
  output logic                      done
);

  state_t              r_state;
  logic [PERIOD_W-1:0] r_timer;
  logic [PERIOD_W-1:0] r_period;
  logic [COUNT_W-1:0]  r_remaining;
  logic                r_fwd;
  logic                r_done;

  logic                w_accept;
  logic                w_due;
  logic                w_step;
  logic                w_last;
  logic [COUNT_W-1:0]  w_mag;
  logic [PERIOD_W-1:0] w_period;

  // Negating the most negative value still yields the right unsigned magnitude
  assign w_mag    = cmd_steps[COUNT_W-1] ? COUNT_W'(-cmd_steps)
                                         : COUNT_W'(cmd_steps);
  assign w_period = (edge_period == '0) ? PERIOD_W'(1) : edge_period;
  assign w_accept = (r_state == IDLE) & cmd_valid & ~abort;
  assign w_due    = (r_state == RUN) & (r_timer == PERIOD_W'(1));
  assign w_step   = w_due & ~abort;
  assign w_last   = (r_remaining == COUNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_period    <= '0;
      r_remaining <= '0;
      r_fwd       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (cmd_steps == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= RUN;
              r_fwd       <= ~cmd_steps[COUNT_W-1];
              r_remaining <= w_mag;
              r_period    <= w_period;
              r_timer     <= w_period;
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_timer     <= '0;
          end else if (w_due) begin
            r_timer     <= r_period;
            r_remaining <= r_remaining - COUNT_W'(1);
            if (w_last) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_timer <= r_timer - PERIOD_W'(1);
          end
        end
      endcase
    end
  end

  assign busy      = (r_state == RUN);
  assign cmd_ready = (r_state == IDLE);
  assign done      = r_done;

  quad_phase_gen #(
    .COUNT_W (COUNT_W)
  ) u_phase (
    .clk        (clk),
    .rst        (rst),
    .i_step     (w_step),
    .i_fwd      (r_fwd),
    .o_ch_a     (ch_A),
    .o_ch_b     (ch_B),
    .o_position (position)
  );

endmodule
